// File: rtl/sc_scaled_addsub_n.sv
// ----------------------------------------------------------------------------
// sc_scaled_addsub_n
// N-input stochastic-computing scaled adder/subtracter. Each accepted cycle
// one input stream is chosen by a select LFSR. The chosen bit is optionally
// inverted (bipolar negation) and emitted, so the output stream encodes
// (1/N)*sum(+/-x_i). A ones counter over STREAM_LEN accepted bits gives the
// binary result.
//
// Optional feature macro: SC_ADDSUB_SIGNED_RESULT_EN
//   defined   : o_signed_result = 2*ones_count - STREAM_LEN, registered with done
//   undefined : o_signed_result tied to zero
//
// Ports
//   clk              rising-edge clock
//   rst_n            asynchronous active-low reset
//   i_start          begin a computation (sampled only in IDLE)
//   i_seed           select-LFSR seed (0 is mapped to all-ones)
//   i_sub_mask       per-channel invert (subtract) mask
//   i_in_bits        one stochastic bit per channel
//   i_in_valid       i_in_bits valid this cycle
//   o_out_bit        selected / inverted bit, registered
//   o_out_valid      o_out_bit valid
//   o_busy           high while running
//   o_done           one-cycle completion pulse
//   o_ones_count     number of ones emitted in this computation
//   o_signed_result  bipolar decode (see macro above)
// ----------------------------------------------------------------------------
module sc_scaled_addsub_n #(
    parameter int N_IN       = 4,
    parameter int SEL_W      = $clog2(N_IN),
    parameter int LFSR_W     = 8,
    parameter int STREAM_LEN = 256,
    parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic [LFSR_W-1:0] i_seed,
    input  logic [N_IN-1:0]   i_sub_mask,
    input  logic [N_IN-1:0]   i_in_bits,
    input  logic              i_in_valid,
    output logic              o_out_bit,
    output logic              o_out_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic [CNT_W-1:0]  o_ones_count,
    output logic [CNT_W:0]    o_signed_result
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Tap masks: 8-bit x^8+x^6+x^5+x^4+1, 16-bit x^16+x^14+x^13+x^11+1.
    localparam logic [LFSR_W-1:0] LP_TAPS = (LFSR_W == 16) ? LFSR_W'(32'h0000_B400)
                                                           : LFSR_W'(32'h0000_00B8);
    localparam logic [CNT_W-1:0]  LP_LAST = CNT_W'(STREAM_LEN - 1);

    // Fibonacci step: shift left, XOR of the tapped bits enters at bit 0.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        logic fb;
        fb = ^(s & LP_TAPS);
        return {s[LFSR_W-2:0], fb};
    endfunction

    state_t              r_state;
    state_t              w_state_next;
    logic [LFSR_W-1:0]   r_lfsr;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [CNT_W-1:0]    r_ones;
    logic                r_out_bit;
    logic                r_out_valid;
    logic                r_busy;
    logic                r_done;

    logic [SEL_W-1:0]    w_sel;
    logic                w_bit;
    logic                w_accept;
    logic                w_last;
    logic [CNT_W-1:0]    w_ones_next;

    assign w_sel       = r_lfsr[SEL_W-1:0];
    assign w_bit       = i_in_bits[w_sel] ^ i_sub_mask[w_sel];
    assign w_accept    = (r_state == ST_RUN) && i_in_valid;
    assign w_last      = w_accept && (r_bit_cnt == LP_LAST);
    assign w_ones_next = r_ones + CNT_W'(w_bit);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; a start coincident with completion is not seen
    // because the FSM is still in RUN on that edge.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: LFSR, counters and registered stream output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr      <= {LFSR_W{1'b1}};
            r_bit_cnt   <= {CNT_W{1'b0}};
            r_ones      <= {CNT_W{1'b0}};
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_busy <= (w_state_next == ST_RUN);
            r_done <= w_last;
            if (r_state == ST_IDLE) begin
                r_out_valid <= 1'b0;
                if (i_start) begin
                    r_lfsr    <= (i_seed == {LFSR_W{1'b0}}) ? {LFSR_W{1'b1}} : i_seed;
                    r_bit_cnt <= {CNT_W{1'b0}};
                    r_ones    <= {CNT_W{1'b0}};
                end else begin
                    r_lfsr <= r_lfsr;
                end
            end else if (i_in_valid) begin
                r_out_bit   <= w_bit;
                r_out_valid <= 1'b1;
                r_ones      <= w_ones_next;
                r_bit_cnt   <= r_bit_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                r_lfsr      <= lfsr_next(r_lfsr);
            end else begin
                // Stall: everything except out_valid holds.
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef SC_ADDSUB_SIGNED_RESULT_EN
    localparam logic [CNT_W:0] LP_LEN_X = (CNT_W+1)'(STREAM_LEN);
    logic [CNT_W:0] r_signed;

    // Bipolar decode 2*ones - STREAM_LEN, captured with the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_signed <= {(CNT_W+1){1'b0}};
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_signed <= {(CNT_W+1){1'b0}};
        end else if (w_last) begin
            r_signed <= {w_ones_next, 1'b0} - LP_LEN_X;
        end else begin
            r_signed <= r_signed;
        end
    end

    assign o_signed_result = r_signed;
`else
    assign o_signed_result = {(CNT_W+1){1'b0}};
`endif

    assign o_out_bit    = r_out_bit;
    assign o_out_valid  = r_out_valid;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_ones_count = r_ones;

endmodule

// File: tb/tb_sc_scaled_addsub_n.sv
module tb_sc_scaled_addsub_n;

    localparam int N_IN = 4;
    localparam int LFSR_W = 8;
    localparam int LEN = 256;
    localparam int CNT_W = 9;

    logic              clk;
    logic              rst_n;
    logic              i_start;
    logic [LFSR_W-1:0] i_seed;
    logic [N_IN-1:0]   i_sub_mask;
    logic [N_IN-1:0]   i_in_bits;
    logic              i_in_valid;
    logic              o_out_bit;
    logic              o_out_valid;
    logic              o_busy;
    logic              o_done;
    logic [CNT_W-1:0]  o_ones_count;
    logic [CNT_W:0]    o_signed_result;

    sc_scaled_addsub_n #(
        .N_IN(N_IN), .LFSR_W(LFSR_W), .STREAM_LEN(LEN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_seed(i_seed),
        .i_sub_mask(i_sub_mask), .i_in_bits(i_in_bits), .i_in_valid(i_in_valid),
        .o_out_bit(o_out_bit), .o_out_valid(o_out_valid), .o_busy(o_busy),
        .o_done(o_done), .o_ones_count(o_ones_count), .o_signed_result(o_signed_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       b;
        logic       last;
        logic [9:0] ones;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_done   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_signed(input int ones);
`ifdef SC_ADDSUB_SIGNED_RESULT_EN
        return 32'(2 * ones - LEN);
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] act_signed();
        logic signed [CNT_W:0] s;
        s = o_signed_result;
        return 32'(int'(s));
    endfunction

    // Reference select LFSR: x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
    function automatic logic [7:0] model_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    // Monitor: pops the scoreboard whenever the DUT presents a valid bit.
    always @(negedge clk) begin
        if (rst_n) begin
            if (o_done) n_done++;
            if (o_out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, o_out_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("out_bit", {31'd0, o_out_bit}, {31'd0, e.b});
                    chk("done_align", {31'd0, o_done}, {31'd0, e.last});
                    if (e.last) begin
                        chk("ones_at_done", {23'd0, o_ones_count}, {22'd0, e.ones});
                        chk("signed_at_done", act_signed(), exp_signed(int'(e.ones)));
                    end
                end
            end else if (o_done) begin
                chk("done_without_valid", {31'd0, o_done}, 32'd0);
            end
        end
    end

    // One computation. hand_ones is the hand-derived final count.
    task automatic run(input logic [7:0] seed, input logic [3:0] bits, input logic [3:0] mask,
                       input bit stall, input bit start_mid, input bit start_end,
                       input int abort_at, input int hand_ones);
        logic [7:0] lfsr;
        int cnt, ones, cyc, done0;
        logic valid, b;
        lfsr  = (seed == 8'd0) ? 8'hFF : seed;
        cnt   = 0;
        ones  = 0;
        cyc   = 0;
        done0 = n_done;
        i_seed  = seed;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        chk("busy_after_start", {31'd0, o_busy}, 32'd1);
        chk("ones_cleared", {23'd0, o_ones_count}, 32'd0);
        while (cnt < LEN) begin
            if (abort_at != 0 && cnt == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_busy", {31'd0, o_busy}, 32'd0);
                chk("abort_valid", {31'd0, o_out_valid}, 32'd0);
                chk("abort_ones", {23'd0, o_ones_count}, 32'd0);
                chk("abort_done", {31'd0, o_done}, 32'd0);
                sb_q.delete();
                i_in_valid = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("abort_no_done", 32'(n_done - done0), 32'd0);
                return;
            end
            valid = stall ? (cyc % 2 == 0) : 1'b1;
            i_in_valid = valid;
            i_in_bits  = bits;
            i_sub_mask = mask;
            i_start    = (start_mid && cnt == 50) || (start_end && cnt == LEN - 1 && valid);
            if (valid) begin
                b = bits[lfsr[1:0]] ^ mask[lfsr[1:0]];
                ones += int'(b);
                cnt++;
                sb_q.push_back('{b: b, last: (cnt == LEN), ones: 10'(ones)});
                lfsr = model_next(lfsr);
            end
            @(negedge clk);
            if (!valid) chk("stall_out_valid", {31'd0, o_out_valid}, 32'd0);
            cyc++;
        end
        i_in_valid = 1'b0;
        i_start    = 1'b0;
        @(negedge clk);
        chk("busy_after_done", {31'd0, o_busy}, 32'd0);
        chk("done_one_cycle", {31'd0, o_done}, 32'd0);
        chk("one_done_pulse", 32'(n_done - done0), 32'd1);
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        chk("model_ones", 32'(ones), 32'(hand_ones));
        if (stall) chk("stall_cycles", 32'(cyc), 32'd511);
        repeat (2) @(negedge clk);
        chk("ones_hold", {23'd0, o_ones_count}, 32'(hand_ones));
        chk("signed_hold", act_signed(), exp_signed(hand_ones));
    endtask

    initial begin
        rst_n      = 1'b0;
        i_start    = 1'b0;
        i_seed     = 8'd0;
        i_sub_mask = 4'd0;
        i_in_bits  = 4'd0;
        i_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_ones", {23'd0, o_ones_count}, 32'd0);
        chk("rst_signed", act_signed(), 32'd0);
        rst_n = 1'b1;
        // in_valid in IDLE must be ignored
        i_in_valid = 1'b1;
        i_in_bits  = 4'hF;
        repeat (3) @(negedge clk);
        chk("idle_out_valid", {31'd0, o_out_valid}, 32'd0);
        chk("idle_ones", {23'd0, o_ones_count}, 32'd0);
        chk("idle_busy", {31'd0, o_busy}, 32'd0);
        i_in_valid = 1'b0;

        // All ones / all inverted / half inverted. Over 256 steps the
        // maximal LFSR visits every nonzero state once plus the seed again.
        run(8'h01, 4'hF, 4'h0, 1'b0, 1'b0, 1'b0, 0, 256);
        run(8'h01, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 0, 0);
        run(8'h01, 4'hF, 4'h3, 1'b0, 1'b0, 1'b0, 0, 128);
        // sel==0 count: 63 nonzero states with low bits 00
        run(8'hA5, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 0, 63);
        run(8'hA5, 4'h1, 4'h0, 1'b1, 1'b0, 1'b0, 0, 63);
        run(8'h00, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 0, 63);
        run(8'hFF, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 0, 63);
        // abort at bit 100, then a clean rerun
        run(8'hA5, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 100, 63);
        run(8'hA5, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 0, 63);
        // start during RUN and coincident with completion are ignored
        run(8'h01, 4'hF, 4'h3, 1'b0, 1'b1, 1'b1, 0, 128);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
